// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver sampling an oversampled serial line.
// Start bit is qualified at mid-bit; data and stop bits are sampled once per bit period.
module uart_rx_oversampled #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in,
  output logic [7:0] out,
  output logic       done,
  output logic       err,
  output logic       busy
);

  localparam int unsigned CNT_W  = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 8;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    WAIT_IDLE = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [1:0]          sync_q, sync_d;
  logic                rx_s;

  assign rx_s   = sync_q[1];
  assign sync_d = {sync_q[0], in};

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    out_d   = out_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && !rx_s) begin
          state_d = START_BIT;
          cnt_d   = '0;
        end
      end
      START_BIT: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA_BITS;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA_BITS: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = STOP_BIT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP_BIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            out_d   = shift_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        // Line must return high before a new start bit can be considered
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      sync_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      sync_q  <= sync_d;
    end
  end

  assign out  = out_q;
  assign done = done_q;
  assign err  = err_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: frames push expected events,
// a negedge monitor pops and compares them as done/err pulses appear.
module tb_uart_rx_oversampled;

  localparam int unsigned OS      = 16;
  localparam int unsigned LATENCY = 8 * OS + OS / 2 + OS;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       in;
  logic [7:0] out;
  logic       done;
  logic       err;
  logic       busy;

  int   checks;
  int   failures;
  exp_t sb[$];
  int   busy_run;
  bit   busy_seen;
  bit   done_prev;
  bit   err_prev;

  uart_rx_oversampled #(.OVERSAMPLE(OS)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .in   (in),
    .out  (out),
    .done (done),
    .err  (err),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame from a negedge; optionally drops en after drop_at cycles
  task automatic send_frame(input logic [7:0] b, input logic stop, input int drop_at,
                            input bit expect_evt);
    logic [9:0] bits;
    int c;
    bits = {stop, b, 1'b0};
    if (expect_evt) sb.push_back('{is_err: ~stop, data: b});
    c = 0;
    for (int i = 0; i < 10; i++) begin
      in = bits[i];
      for (int k = 0; k < int'(OS); k++) begin
        @(negedge clk);
        c++;
        if (c == drop_at) en = 1'b0;
      end
    end
  endtask

  // Monitor: pops the scoreboard on each done/err pulse and checks latency
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (busy) busy_seen = 1'b1;
      if (done || err) begin
        check("done_err_excl", 32'(done & err), 32'd0);
        check("pulse_width", 32'({done & done_prev, err & err_prev}), 32'd0);
        check("latency", 32'(busy_run), 32'(LATENCY));
        if (sb.size() == 0) begin
          check("unexpected_evt", 32'({done, err}), 32'd0);
        end else begin
          e = sb.pop_front();
          check("evt_kind", 32'(err), 32'(e.is_err));
          if (done) check("rx_data", 32'(out), 32'(e.data));
        end
        busy_run = 0;
      end else if (busy) begin
        busy_run++;
      end else begin
        busy_run = 0;
      end
      done_prev = done;
      err_prev  = err;
    end else begin
      busy_run  = 0;
      done_prev = 1'b0;
      err_prev  = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    busy_run  = 0;
    busy_seen = 1'b0;
    done_prev = 1'b0;
    err_prev  = 1'b0;
    rst = 1'b1;
    en  = 1'b0;
    in  = 1'b1;
    idle_cycles(3);
    check("rst_out", 32'(out), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle_cycles(5);
    en = 1'b1;

    // Basic frame
    send_frame(8'hA5, 1'b1, -1, 1'b1);
    idle_cycles(20);
    check("a5_drain", 32'(sb.size()), 32'd0);
    check("a5_out", 32'(out), 32'hA5);

    // False start: short low glitch
    in = 1'b0;
    idle_cycles(4);
    in = 1'b1;
    idle_cycles(2);
    check("fs_busy_hi", 32'(busy), 32'd1);
    idle_cycles(30);
    check("fs_busy_lo", 32'(busy), 32'd0);
    check("fs_out", 32'(out), 32'hA5);

    // Framing error, line held low afterwards
    send_frame(8'h3C, 1'b0, -1, 1'b1);
    in = 1'b0;
    idle_cycles(40);
    check("fe_drain", 32'(sb.size()), 32'd0);
    check("fe_busy_hold", 32'(busy), 32'd1);
    in = 1'b1;
    idle_cycles(5);
    check("fe_busy_rel", 32'(busy), 32'd0);
    check("fe_out_kept", 32'(out), 32'hA5);

    // Back-to-back frames
    send_frame(8'h00, 1'b1, -1, 1'b1);
    send_frame(8'hFF, 1'b1, -1, 1'b1);
    idle_cycles(20);
    check("b2b_drain", 32'(sb.size()), 32'd0);
    check("b2b_out", 32'(out), 32'hFF);

    // Receiver disabled for a whole frame
    en = 1'b0;
    busy_seen = 1'b0;
    send_frame(8'h77, 1'b1, -1, 1'b0);
    idle_cycles(20);
    check("dis_busy_seen", 32'(busy_seen), 32'd0);
    check("dis_out", 32'(out), 32'hFF);

    // en dropped after start accepted
    en = 1'b1;
    send_frame(8'hC3, 1'b1, 8, 1'b1);
    idle_cycles(20);
    check("endrop_drain", 32'(sb.size()), 32'd0);
    check("endrop_out", 32'(out), 32'hC3);
    en = 1'b1;

    // Reset in the middle of data bit 4 of 0x5A
    begin
      logic [9:0] bits;
      bits = {1'b1, 8'h5A, 1'b0};
      for (int i = 0; i < 5; i++) begin
        in = bits[i];
        idle_cycles(OS);
      end
      in = bits[5];
      idle_cycles(8);
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out", 32'(out), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    in = 1'b1;
    idle_cycles(3);
    rst = 1'b0;
    idle_cycles(20);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_out", 32'(out), 32'd0);
    send_frame(8'h81, 1'b1, -1, 1'b1);
    idle_cycles(20);
    check("r81_drain", 32'(sb.size()), 32'd0);
    check("r81_out", 32'(out), 32'h81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
